ssp_tx_fifo: RTL

Transmit FIFO for the SSP serial port. It accepts bytes from the APB write side on `PCLK` and presents the oldest byte to the SSP transmit/receive logic as `TxData`/`tx_ready`. It retires a byte when that logic signals the end of a frame by raising `transmit_complete`. It is the producer end of the `tx_ready`/`TxData`/`transmit_complete` handshake and holds the head word stable for the whole 8-bit frame.

---
 rtl/ssp_tx_fifo_pkg.sv | 19 +
 rtl/ssp_fifo_mem.sv | 43 ++++
 rtl/ssp_tx_fifo.sv | 115 +++++++++++
 3 files changed

// File: rtl/ssp_tx_fifo_pkg.sv
// ============================================================================
// Module      : ssp_tx_fifo_pkg
// Description : Constants shared by the SSP transmit and receive FIFOs.
//               SSP_DATA_W       - serial word width
//               SSP_TXFIFO_DEPTH - FIFO entries (power of two, >= 2)
//               SSP_TXFIFO_PTR_W - pointer width derived from the depth
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ssp_tx_fifo_pkg;

    localparam int SSP_DATA_W       = 8;
    localparam int SSP_TXFIFO_DEPTH = 4;
    localparam int SSP_TXFIFO_PTR_W = $clog2(SSP_TXFIFO_DEPTH);

endpackage : ssp_tx_fifo_pkg

`default_nettype wire

// File: rtl/ssp_fifo_mem.sv
// ============================================================================
// Module      : ssp_fifo_mem
// Description : Register-array storage for the SSP FIFOs.
//               Synchronous write port, asynchronous read port.
//               Contents are deliberately not reset.
// Ports       : clk   - write clock
//               we    - write enable
//               waddr - write address
//               wdata - write data
//               raddr - read address
//               rdata - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssp_fifo_mem
    import ssp_tx_fifo_pkg::*;
#(
    parameter int DATA_W = SSP_DATA_W,
    parameter int DEPTH  = SSP_TXFIFO_DEPTH,
    parameter int ADDR_W = SSP_TXFIFO_PTR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : ssp_fifo_mem

`default_nettype wire

// File: rtl/ssp_tx_fifo.sv
// ============================================================================
// Module      : ssp_tx_fifo
// Description : SSP transmit FIFO. Accepts words from the APB write side and
//               presents the oldest one to the SSP shifter; a word is retired
//               on the 0->1 edge of transmit_complete (end of frame).
// Ports       : PCLK              - clock
//               CLEAR             - asynchronous active-high reset
//               PSEL, PWRITE      - push request when both high
//               PWDATA            - word to push
//               transmit_complete - low while a frame shifts, rise = frame end
//               TxData            - head word (combinational read)
//               tx_ready          - head valid and may be started
//               TxFull, TxEmpty   - occupancy flags (registered state)
//               TxCount           - occupancy 0..DEPTH
//               TxOverflow        - pulse when a push is dropped (FIFO full)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssp_tx_fifo
    import ssp_tx_fifo_pkg::*;
#(
    parameter int DATA_W = SSP_DATA_W,
    parameter int DEPTH  = SSP_TXFIFO_DEPTH
) (
    input  logic                       PCLK,
    input  logic                       CLEAR,
    input  logic                       PSEL,
    input  logic                       PWRITE,
    input  logic [DATA_W-1:0]          PWDATA,
    input  logic                       transmit_complete,
    output logic [DATA_W-1:0]          TxData,
    output logic                       tx_ready,
    output logic                       TxFull,
    output logic                       TxEmpty,
    output logic [$clog2(DEPTH):0]     TxCount,
    output logic                       TxOverflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_tc_q;

    logic w_rise;
    logic w_req;
    logic w_push;
    logic w_pop;

    // Flags come only from registered state, never from the request inputs.
    assign TxFull  = (r_count == c_CNT_FULL);
    assign TxEmpty = (r_count == '0);
    assign TxCount = r_count;

    // tc_q resets high so a consumer idling with transmit_complete high
    // never produces a spurious frame end after reset.
    assign w_rise = transmit_complete && !r_tc_q;
    assign w_pop  = w_rise && !TxEmpty;
    assign w_req  = PSEL && PWRITE;
    assign w_push = w_req && !TxFull;

    // A full FIFO drops the request even when a pop frees a slot this cycle.
    assign TxOverflow = w_req && TxFull;

    // Masked during the rise cycle so the consumer cannot restart on the
    // head word that is about to be retired.
    assign tx_ready = !TxEmpty && !w_rise;

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_tc_q   <= 1'b1;
        end else begin
            r_tc_q <= transmit_complete;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Pushes write at wr_ptr only; the head entry at rd_ptr is never touched
    // while it is occupied, so TxData holds steady for the whole frame.
    ssp_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk    (PCLK),
        .we     (w_push),
        .waddr  (r_wr_ptr),
        .wdata  (PWDATA),
        .raddr  (r_rd_ptr),
        .rdata  (TxData)
    );

endmodule : ssp_tx_fifo

`default_nettype wire
